// File: rtl/seq_div_16.sv
// seq_div_16: iterative 16-bit restoring divider, one quotient bit per clock.
// Latency: 17 clocks from accepted start to done (1 clock for divide-by-zero); 18-clock throughput.
// Backpressure: start is sampled only in IDLE; start in RUN/DONE is ignored, operands are not re-sampled.
//
// Ports:
//   clk, reset (synchronous, active-high)
//   start, dividend[15:0], divisor[15:0]      request and operands, sampled together in IDLE
//   busy                                      high while iterating (RUN)
//   done                                      one-cycle pulse, results valid
//   quotient[15:0], remainder[15:0]           registered results, held in IDLE
//   div_by_zero                               registered flag, held until the next accepted start
// Optional feature: define SEQ_DIV_SIGNED_EN for two's-complement operands (truncating
// quotient, remainder takes the dividend's sign). Default build is unsigned.
module seq_div_16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  // Partial remainder is always < divisor after a restoring step, so its bit 16 is
  // always zero and only the low 16 bits are stored; bit 16 lives only in the trial.
  logic [15:0] r_q, r_d;
  logic [15:0] q_q, q_d;
  logic [15:0] d_q, d_d;
  logic [15:0] quot_q, quot_d;
  logic [15:0] rem_q, rem_d;
  logic        dbz_q, dbz_d;

  logic [16:0] r_sh;
  logic [16:0] trial;
  logic [15:0] r_step, q_step;
  logic [15:0] a_in, b_in;
  logic [15:0] q_fin, r_fin;
  logic        accept;

  assign accept = (state_q == S_IDLE) && start;

  // One restoring iteration: shift in the next dividend bit, try subtracting the divisor.
  always_comb begin
    r_sh   = {r_q, q_q[15]};
    trial  = r_sh + ~{1'b0, d_q} + 17'd1;
    // trial[16] set means the subtraction borrowed: keep the shifted remainder.
    r_step = trial[16] ? r_sh[15:0] : trial[15:0];
    q_step = {q_q[14:0], ~trial[16]};
  end

`ifdef SEQ_DIV_SIGNED_EN
  logic qneg_q, rneg_q;

  // Core always divides magnitudes; 16'h8000 maps to itself, which is its correct unsigned magnitude.
  always_comb begin
    a_in  = dividend[15] ? (~dividend + 16'd1) : dividend;
    b_in  = divisor[15]  ? (~divisor  + 16'd1) : divisor;
    q_fin = qneg_q ? (~q_step + 16'd1) : q_step;
    r_fin = rneg_q ? (~r_step + 16'd1) : r_step;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else if (accept) begin
      qneg_q <= dividend[15] ^ divisor[15];
      rneg_q <= dividend[15];
    end
  end
`else
  always_comb begin
    a_in  = dividend;
    b_in  = divisor;
    q_fin = q_step;
    r_fin = r_step;
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (divisor == 16'd0) begin
            state_d = S_DONE;
            quot_d  = 16'hFFFF;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = S_RUN;
            cnt_d   = 4'd0;
            r_d     = 16'd0;
            q_d     = a_in;
            d_d     = b_in;
            dbz_d   = 1'b0;
          end
        end
      end
      S_RUN: begin
        r_d   = r_step;
        q_d   = q_step;
        cnt_d = cnt_q + 4'd1;
        // Results are registered on the edge that enters DONE, using this cycle's final step.
        if (cnt_q == 4'd15) begin
          state_d = S_DONE;
          quot_d  = q_fin;
          rem_d   = r_fin;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      r_q     <= 16'd0;
      q_q     <= 16'd0;
      d_q     <= 16'd0;
      quot_q  <= 16'd0;
      rem_q   <= 16'd0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div_16.sv
// tb_seq_div_16: directed-vector bench for seq_div_16 with hand-computed results.
// Covers reset state, latency/busy length, extremes, divide-by-zero, handshake, reset mid-run.
// Signed vectors run when SEQ_DIV_SIGNED_EN is defined.
module tb_seq_div_16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int n_checks = 0;
  int n_pass   = 0;

  seq_div_16 dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Issue one request from IDLE and check latency, busy length and results.
  task automatic run_div(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] eq, input logic [15:0] er, input logic edbz,
                         input int elat);
    int lat;
    int bcnt;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start = 1'b0;
    lat   = 1;
    bcnt  = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      tick();
      lat++;
    end
    chk({tag, ".lat"},  lat,         elat);
    chk({tag, ".busy"}, bcnt,        (elat == 1) ? 0 : 16);
    chk({tag, ".q"},    quotient,    eq);
    chk({tag, ".r"},    remainder,   er);
    chk({tag, ".dbz"},  div_by_zero, edbz);
    tick();
    chk({tag, ".pulse"}, done, 1'b0);
  endtask

  initial begin
    int cyc;
    int ndone;
    reset    = 1'b1;
    start    = 1'b0;
    dividend = 16'd0;
    divisor  = 16'd0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst.busy", busy,        1'b0);
    chk("rst.done", done,        1'b0);
    chk("rst.q",    quotient,    16'd0);
    chk("rst.r",    remainder,   16'd0);
    chk("rst.dbz",  div_by_zero, 1'b0);

    run_div("basic", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17);
`ifndef SEQ_DIV_SIGNED_EN
    run_div("max_by_1",   16'hFFFF, 16'd1,    16'hFFFF, 16'd0, 1'b0, 17);
    run_div("small_big",  16'd5,    16'hFFFF, 16'd0,    16'd5, 1'b0, 17);
    run_div("max_by_max", 16'hFFFF, 16'hFFFF, 16'd1,    16'd0, 1'b0, 17);
`endif
    run_div("dbz",       16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1, 1);
    run_div("after_dbz", 16'd10,   16'd3, 16'd3,    16'd1,    1'b0, 17);

    // start pulsed mid-run and in the DONE cycle must not disturb or re-trigger.
    dividend = 16'd200;
    divisor  = 16'd9;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    dividend = 16'd50;
    divisor  = 16'd5;
    start    = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 6;
    while (!done && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("hs.lat", cyc,       17);
    chk("hs.q",   quotient,  16'd22);
    chk("hs.r",   remainder, 16'd2);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("hs.idle_busy", busy, 1'b0);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      if (done || busy) ndone++;
      tick();
    end
    chk("hs.no_retrigger", ndone, 0);

    // start held high: back-to-back results every 18 clocks.
    dividend = 16'd10;
    divisor  = 16'd3;
    start    = 1'b1;
    cyc      = 0;
    while (!done && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("held.first_q", quotient, 16'd3);
    for (int k = 0; k < 2; k++) begin
      tick();
      cyc = 1;
      while (!done && cyc < 40) begin
        tick();
        cyc++;
      end
      chk("held.interval", cyc, 18);
    end
    start = 1'b0;
    tick();

    // Reset during RUN cycle 8 clears everything and suppresses done.
    dividend = 16'd1000;
    divisor  = 16'd7;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    chk("rr.busy_before", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rr.busy", busy,        1'b0);
    chk("rr.done", done,        1'b0);
    chk("rr.q",    quotient,    16'd0);
    chk("rr.r",    remainder,   16'd0);
    chk("rr.dbz",  div_by_zero, 1'b0);
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      if (done) ndone++;
      tick();
    end
    chk("rr.no_done", ndone, 0);
    run_div("after_rst", 16'd81, 16'd9, 16'd9, 16'd0, 1'b0, 17);

`ifdef SEQ_DIV_SIGNED_EN
    run_div("s_neg_pos", 16'hFFF9, 16'd2,    16'hFFFD, 16'hFFFF, 1'b0, 17);
    run_div("s_pos_neg", 16'd7,    16'hFFFE, 16'hFFFD, 16'd1,    1'b0, 17);
    run_div("s_ovf",     16'h8000, 16'hFFFF, 16'h8000, 16'd0,    1'b0, 17);
    run_div("s_dbz",     16'hFFF9, 16'd0,    16'hFFFF, 16'hFFF9, 1'b1, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
